// File: rtl/lcd_write_byte_if.sv
// rtl/lcd_write_byte_if.sv - byte-write handshake between LCD controllers and the nibble writer

interface lcd_write_byte_if;
   logic       doWriteByte;
   logic [7:0] dataIn;
   logic       writeRS;
   logic       writeByteReady;
   logic       writeByteDone;

   modport master (
      output doWriteByte, dataIn, writeRS,
      input  writeByteReady, writeByteDone
   );

   modport slave (
      input  doWriteByte, dataIn, writeRS,
      output writeByteReady, writeByteDone
   );
endinterface

// File: rtl/lcd_write_byte.sv
// rtl/lcd_write_byte.sv - splits one byte into two timed LCD_E nibble writes on the 4-bit LCD bus

module lcd_write_byte #(
   parameter int SETUP_CYC    = 2,
   parameter int PULSE_CYC    = 12,
   parameter int HOLD_CYC     = 1,
   parameter int GAP_NIB_CYC  = 50,
   parameter int GAP_BYTE_CYC = 2000
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   lcd_write_byte_if.slave         wr,
   output logic                    LCD_E,
   output logic                    LCD_RS,
   output logic                    LCD_RW,
   output logic [3:0]              LCD_DB
);

   localparam int MAX_A  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAX_B  = (HOLD_CYC > GAP_NIB_CYC) ? HOLD_CYC : GAP_NIB_CYC;
   localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_P  = (MAX_C > GAP_BYTE_CYC) ? MAX_C : GAP_BYTE_CYC;
   localparam int CW     = $clog2(MAX_P + 1);

   // Counter holds cycles remaining minus one, so a state ends when it reads zero.
   localparam logic [CW-1:0] SETUP_L    = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] PULSE_L    = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] HOLD_L     = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] GAP_NIB_L  = CW'(GAP_NIB_CYC - 1);
   localparam logic [CW-1:0] GAP_BYTE_L = CW'(GAP_BYTE_CYC - 1);

   typedef enum logic [3:0] {
      IDLE, UP_SETUP, UP_PULSE, UP_HOLD, GAP_NIB,
      LO_SETUP, LO_PULSE, LO_HOLD, GAP_BYTE, DONE
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      data_q, data_d;
   logic            rs_q, rs_d;
   logic            e_q, e_d;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= 8'h00;
         rs_q    <= 1'b0;
         e_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
         e_q     <= e_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      rs_d    = rs_q;

      case (state_q)
         IDLE: begin
            if (wr.doWriteByte) begin
               data_d  = wr.dataIn;
               rs_d    = wr.writeRS;
               state_d = UP_SETUP;
            end
         end
         DONE: state_d = IDLE;
         default: begin
            if (cnt_q == '0) begin
               case (state_q)
                  UP_SETUP: state_d = UP_PULSE;
                  UP_PULSE: state_d = UP_HOLD;
                  UP_HOLD:  state_d = GAP_NIB;
                  GAP_NIB:  state_d = LO_SETUP;
                  LO_SETUP: state_d = LO_PULSE;
                  LO_PULSE: state_d = LO_HOLD;
                  LO_HOLD:  state_d = GAP_BYTE;
                  default:  state_d = DONE;
               endcase
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase

      // Reload on every state change so each state gets its full duration.
      if (state_d != state_q) begin
         case (state_d)
            UP_SETUP, LO_SETUP: cnt_d = SETUP_L;
            UP_PULSE, LO_PULSE: cnt_d = PULSE_L;
            UP_HOLD,  LO_HOLD:  cnt_d = HOLD_L;
            GAP_NIB:            cnt_d = GAP_NIB_L;
            GAP_BYTE:           cnt_d = GAP_BYTE_L;
            default:            cnt_d = '0;
         endcase
      end

      // LCD_E comes straight from a flop, decoded from the next state.
      e_d = (state_d == UP_PULSE) || (state_d == LO_PULSE);
   end

   always_comb begin
      LCD_DB = 4'h0;
      case (state_q)
         UP_SETUP, UP_PULSE, UP_HOLD:                      LCD_DB = data_q[7:4];
         GAP_NIB, LO_SETUP, LO_PULSE, LO_HOLD, GAP_BYTE:   LCD_DB = data_q[3:0];
         default:                                          LCD_DB = 4'h0;
      endcase
   end

   assign LCD_E             = e_q;
   assign LCD_RS            = (state_q != IDLE) ? rs_q : 1'b0;
   assign LCD_RW            = 1'b0;
   assign wr.writeByteReady = (state_q == IDLE);
   assign wr.writeByteDone  = (state_q == DONE);

endmodule

// File: tb/tb_lcd_write_byte.sv
// tb/tb_lcd_write_byte.sv - directed self-checking bench for lcd_write_byte

module tb_lcd_write_byte;

   logic       CLK;
   logic       RESET_N;
   logic       LCD_E;
   logic       LCD_RS;
   logic       LCD_RW;
   logic [3:0] LCD_DB;

   int n_vec  = 0;
   int n_fail = 0;

   lcd_write_byte_if bus ();

   lcd_write_byte dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .wr      (bus.slave),
      .LCD_E   (LCD_E),
      .LCD_RS  (LCD_RS),
      .LCD_RW  (LCD_RW),
      .LCD_DB  (LCD_DB)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ready"}, 16'(bus.writeByteReady), 16'h1);
      chk({tag, "_done"},  16'(bus.writeByteDone),  16'h0);
      chk({tag, "_e"},     16'(LCD_E),              16'h0);
      chk({tag, "_db"},    16'(LCD_DB),             16'h0);
      chk({tag, "_rs"},    16'(LCD_RS),             16'h0);
      chk({tag, "_rw"},    16'(LCD_RW),             16'h0);
   endtask

   // Starts at the acceptance edge T0 and checks cycles 1..2082 at the falling edge.
   task automatic xfer(input logic [7:0] b, input logic rs, input bit hold,
                       input bit nxt_do, input logic [7:0] nxt_data,
                       input bit scramble, input string tag);
      logic       e_x, rs_x, done_x, rdy_x;
      logic [3:0] db_x;
      @(posedge CLK);
      for (int k = 1; k <= 2082; k++) begin
         @(negedge CLK);
         e_x    = ((k >= 3) && (k <= 14)) || ((k >= 68) && (k <= 79));
         db_x   = (k <= 15) ? b[7:4] : (k <= 2080) ? b[3:0] : 4'h0;
         rs_x   = (k <= 2081) ? rs : 1'b0;
         done_x = (k == 2081);
         rdy_x  = (k == 2082);
         chk({tag, "_e"},     16'(LCD_E),              16'(e_x));
         chk({tag, "_db"},    16'(LCD_DB),             16'(db_x));
         chk({tag, "_rs"},    16'(LCD_RS),             16'(rs_x));
         chk({tag, "_rw"},    16'(LCD_RW),             16'h0);
         chk({tag, "_done"},  16'(bus.writeByteDone),  16'(done_x));
         chk({tag, "_ready"}, 16'(bus.writeByteReady), 16'(rdy_x));
         if (k == 1 && !hold) bus.doWriteByte = 1'b0;
         if (scramble) begin
            bus.doWriteByte = 1'b0;
            bus.dataIn      = 8'hFF;
            bus.writeRS     = ~bus.writeRS;
         end
         if (k == 2081 && hold) begin
            bus.doWriteByte = nxt_do;
            bus.dataIn      = nxt_data;
         end
      end
   endtask

   initial begin
      int done_cnt;
      RESET_N         = 1'b0;
      bus.doWriteByte = 1'b0;
      bus.dataIn      = 8'h00;
      bus.writeRS     = 1'b0;

      // Reset with random inputs
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         bus.doWriteByte = 1'($urandom);
         bus.dataIn      = 8'($urandom);
         bus.writeRS     = 1'($urandom);
         @(negedge CLK);
         chk_idle("rst");
      end
      bus.doWriteByte = 1'b0;
      RESET_N = 1'b1;
      repeat (5) @(negedge CLK);
      chk_idle("post_rst");

      // Single command, one-cycle request
      bus.doWriteByte = 1'b1;
      bus.dataIn      = 8'h28;
      bus.writeRS     = 1'b0;
      xfer(8'h28, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "cmd28");
      repeat (3) @(negedge CLK);
      chk_idle("cmd28_after");

      // Back-to-back, upstream holds request until done
      bus.doWriteByte = 1'b1;
      bus.dataIn      = 8'h28;
      bus.writeRS     = 1'b0;
      xfer(8'h28, 1'b0, 1'b1, 1'b1, 8'h06, 1'b0, "b2b_28");
      xfer(8'h06, 1'b0, 1'b1, 1'b0, 8'h06, 1'b0, "b2b_06");
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         chk("b2b_idle_ready", 16'(bus.writeByteReady), 16'h1);
         chk("b2b_idle_e",     16'(LCD_E),              16'h0);
      end

      // Data write
      bus.doWriteByte = 1'b1;
      bus.dataIn      = 8'h41;
      bus.writeRS     = 1'b1;
      xfer(8'h41, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "data41");

      // Input changes after acceptance are ignored
      @(negedge CLK);
      bus.doWriteByte = 1'b1;
      bus.dataIn      = 8'hA5;
      bus.writeRS     = 1'b0;
      xfer(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "ignA5");
      bus.writeRS = 1'b0;

      // Reset during the first E pulse
      @(negedge CLK);
      bus.doWriteByte = 1'b1;
      bus.dataIn      = 8'h3C;
      bus.writeRS     = 1'b1;
      @(posedge CLK);
      #1 bus.doWriteByte = 1'b0;
      repeat (7) @(posedge CLK);
      #2;
      chk("mid_e_before", 16'(LCD_E),  16'h1);
      chk("mid_db_before", 16'(LCD_DB), 16'h3);
      RESET_N = 1'b0;
      #1;
      chk_idle("mid_rst");
      @(negedge CLK);
      chk_idle("mid_rst_hold");
      RESET_N = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 2200; i++) begin
         @(negedge CLK);
         if (bus.writeByteDone === 1'b1) done_cnt++;
      end
      chk("mid_no_done", 16'(done_cnt), 16'h0);
      chk_idle("mid_after");

      bus.doWriteByte = 1'b1;
      bus.dataIn      = 8'h5A;
      bus.writeRS     = 1'b1;
      xfer(8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "after5A");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
